// File: rtl/serial_adder_ctrl_if.sv
// Operand/result bundle for the bit-serial adder.
// Handshake: the master raises START with A/B/CIN valid; the slave accepts it
// only on an edge where it is idle or finishing (BUSY=0), and answers WIDTH+1
// cycles later with a one-cycle DONE while SUM/COUT hold the result.
// START seen while BUSY=1 is dropped, not queued.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic [1:0]       STATE_DBG;

  modport master (
    output START, A, B, CIN,
    input  BUSY, DONE, SUM, COUT, STATE_DBG
  );

  modport slave (
    input  START, A, B, CIN,
    output BUSY, DONE, SUM, COUT, STATE_DBG
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first over
// WIDTH cycles, feeding its carry back through a register. The result is
// published on the edge entering DONE and held until the next DONE.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST,
  serial_adder_ctrl_if.slave bus
);

  // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             w_load;
  logic             w_last;
  logic             w_busy;
  logic             w_done;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_sum_next;
  logic             r_carry;
  logic             r_cout;
  logic             w_fa_s;
  logic             w_fa_c;

  assign w_last = (r_cnt == LAST_BIT);

  // Single full-adder cell on the current LSBs and the carry register.
  always_comb begin
    w_fa_s = r_op_a[0] ^ r_op_b[0] ^ r_carry;
    w_fa_c = (r_op_a[0] & r_op_b[0]) | (r_carry & (r_op_a[0] ^ r_op_b[0]));
  end

  // New sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign w_sum_next = w_fa_s;
    end else begin : g_sum_wn
      assign w_sum_next = {w_fa_s, r_sum_sh[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, operand-load strobe and status outputs.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.START) begin
          w_load       = 1'b1;
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        if (bus.START) begin
          w_load       = 1'b1;
          w_next_state = S_RUN;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: capture on load, shift/accumulate during RUN, publish on exit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else if (w_load) begin
      r_cnt    <= '0;
      r_op_a   <= bus.A;
      r_op_b   <= bus.B;
      r_sum_sh <= '0;
      r_carry  <= bus.CIN;
    end else if (r_state == S_RUN) begin
      r_cnt    <= r_cnt + CW'(1);
      r_op_a   <= r_op_a >> 1;
      r_op_b   <= r_op_b >> 1;
      r_sum_sh <= w_sum_next;
      r_carry  <= w_fa_c;
      if (w_last) begin
        r_sum  <= w_sum_next;
        r_cout <= w_fa_c;
      end
    end
  end

  assign bus.BUSY      = w_busy;
  assign bus.DONE      = w_done;
  assign bus.SUM       = r_sum;
  assign bus.COUT      = r_cout;
  assign bus.STATE_DBG = r_state;

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller: accepts two WIDTH-bit operands and a carry-in on a start handshake, then sequences a single internal FullAdder instance over WIDTH cycles, LSB first. A registered carry feeds each bit's carry-out back as the next bit's carry-in. Sum and carry-out are presented as a held result with a one-cycle done pulse. It is the area-minimal alternative to a ripple chain of FullAdders: one adder cell plus counter, shift and carry registers.

## Interface

Parameters:
- WIDTH, default 8: operand/sum width in bits; legal range WIDTH ≥ 1.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  reset; synchronous, active-high.
- START  input  1  request to begin an addition; sampled only in IDLE or DONE state.
- A  input  WIDTH  operand A; captured on the accepted START edge.
- B  input  WIDTH  operand B; captured on the accepted START edge.
- CIN  input  1  carry-in; captured on the accepted START edge.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse; high for exactly the cycle in DONE state.
- SUM  output  WIDTH  registered result A+B+CIN mod 2^WIDTH.
- COUT  output  1  registered carry-out of bit WIDTH-1.

## Operation

- The clock is CLK. Reset is synchronous and active-high on RST. RST takes priority over every other input.
- Reset values:
  - State is IDLE, bit counter is 0, and the internal carry register is 0.
  - BUSY=0, DONE=0, SUM=0, COUT=0.
- States are IDLE, RUN and DONE.
  - IDLE: if START=1, latch A and B into operand shift registers, load the carry register with CIN, clear the counter, and go to RUN. Otherwise stay in IDLE.
  - RUN: the FullAdder receives A=opA[0], B=opB[0], X=carry register.
  - RUN, each edge:
    - Shift the FA S output into the MSB of the sum shift register.
    - Shift both operand registers right by one.
    - Load the carry register with the FA C output.
    - Increment the counter.
  - RUN exit: on the edge where counter == WIDTH-1, go to DONE. On that same edge, copy the completed sum shift value into SUM and the FA C output into COUT.
  - DONE: DONE=1 for this one cycle. If START=1, capture new operands exactly as from IDLE and go to RUN. Otherwise go to IDLE.
- START while in RUN is ignored and not queued. A, B and CIN changes during RUN have no effect.
- SUM and COUT change only on the edge entering DONE. They hold their value through IDLE and through the next RUN until the next DONE.
- The counter width is enough to hold WIDTH-1, with a minimum of 1 bit.
- WIDTH=1: the block spends exactly one RUN cycle.

## Timing

- START is high in cycle 0 while the block is in IDLE or DONE. RUN covers cycles 1..WIDTH, with BUSY=1.
- In cycle WIDTH+1, DONE=1 and BUSY=0, and the new SUM/COUT are visible.
- Latency from START to DONE is WIDTH+1 cycles.
- Throughput is one addition per WIDTH+1 cycles when START is held or re-asserted in the DONE cycle. There are no idle bubbles between operations.
- Reset mid-RUN:
  - The operation is aborted and no DONE pulse is produced.
  - SUM and COUT return to 0 on the reset edge.
  - START asserted together with RST is ignored.
- BUSY and DONE are never high in the same cycle.

## Test plan

- Basic add, WIDTH=8: A=8'h5A, B=8'h3C, CIN=0, one-cycle START.
  - Required: BUSY high in cycles 1–8, DONE pulse in cycle 9, SUM=8'h96, COUT=0.
- Carry ripple through all bits: A=8'hFF, B=8'h01, CIN=0.
  - Required: SUM=8'h00, COUT=1.
- Maximum sum: A=8'hFF, B=8'hFF, CIN=1.
  - Required: SUM=8'hFF, COUT=1.
  - After this, an add of A=0, B=0, CIN=0 must give SUM=0, COUT=0, which proves the carry register reloads from CIN.
- START pulsed in cycle 3 of RUN, with different operands.
  - Required: it is ignored. The DONE pulse occurs only once, in cycle 9, with the original result, and BUSY stays 0 afterwards.
- Back-to-back: START held high continuously with A=8'h01, B=8'h01, changing to A=8'h10, B=8'h20 in the DONE cycle.
  - Required: DONE in cycle 9 with SUM=8'h02.
  - Required: DONE in cycle 18 with SUM=8'h30.
  - BUSY is low only in the DONE cycles.
- Reset mid-operation: RST asserted in cycle 4 of RUN.
  - Required: the next cycle has BUSY=0, DONE=0, SUM=0, COUT=0, and no DONE pulse follows.
  - Repeat with WIDTH=1: A=1, B=1, CIN=1 gives DONE in cycle 2, SUM=1, COUT=1.
